// File: rtl/rgb_pwm_driver_if.sv
// rgb_pwm_driver_if: valid/ready duty-triple bus between a colour source and the PWM driver.
interface rgb_pwm_driver_if #(parameter int WIDTH = 8);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] b;
    modport master(output valid, r, g, b, input ready);
    modport slave(input valid, r, g, b, output ready);
endinterface

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: three-channel PWM LED driver, duty triples double-buffered and applied at frame boundaries.
// Optional RGB_PWM_FADE_EN: active duty ramps one step per frame toward the last accepted triple.
module rgb_pwm_driver #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable_i,
    rgb_pwm_driver_if.slave       cfg,
    output logic                  led_r_o,
    output logic                  led_g_o,
    output logic                  led_b_o,
    output logic                  frame_start_o
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;

    logic [0:0]            state_q, state_d;
    logic [PW-1:0]         pre_q, pre_d;
    logic [WIDTH-1:0]      cnt_q, cnt_d;
    logic [2:0][WIDTH-1:0] pnd_q, pnd_d, act_q, act_d;
    logic                  pend_q, pend_d;
    logic [2:0]            led_q, led_d;
    logic                  fs_q, fs_d;
    logic                  run, tick, boundary, xfer, load;
`ifdef RGB_PWM_FADE_EN
    logic [2:0][WIDTH-1:0] tgt_q, tgt_d;
`endif

    // run also needs enable so leds and counters drop on the edge enable is seen low
    assign run      = state_q == RUN && enable_i;
    assign tick     = state_q == RUN && pre_q == PW'(PRESCALE - 1);
    assign boundary = tick && &cnt_q;
    assign xfer     = cfg.valid && !pend_q;
    assign load     = pend_q && (boundary || state_q == IDLE);
    assign cfg.ready = !pend_q;

    always_comb begin
        state_d = enable_i ? RUN : IDLE;
        pre_d   = run && !tick ? pre_q + 1'b1 : '0;
        cnt_d   = run ? cnt_q + WIDTH'(tick) : '0;
        pnd_d   = xfer ? {cfg.b, cfg.g, cfg.r} : pnd_q;
        pend_d  = xfer || (pend_q && !load);
        fs_d    = boundary;
`ifdef RGB_PWM_FADE_EN
        tgt_d   = load ? pnd_q : tgt_q;
        act_d   = act_q;
        for (int i = 0; i < 3; i++)
            act_d[i] = state_q == IDLE     ? tgt_d[i] :
                       !boundary           ? act_q[i] :
                       act_q[i] < tgt_q[i] ? act_q[i] + 1'b1 :
                       act_q[i] > tgt_q[i] ? act_q[i] - 1'b1 : act_q[i];
`else
        act_d   = load ? pnd_q : act_q;
`endif
        led_d   = '0;
        for (int i = 0; i < 3; i++)
            led_d[i] = run && cnt_q < act_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pre_q   <= '0;
            cnt_q   <= '0;
            pnd_q   <= '0;
            act_q   <= '0;
            pend_q  <= 1'b0;
            led_q   <= '0;
            fs_q    <= 1'b0;
`ifdef RGB_PWM_FADE_EN
            tgt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            pnd_q   <= pnd_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            led_q   <= led_d;
            fs_q    <= fs_d;
`ifdef RGB_PWM_FADE_EN
            tgt_q   <= tgt_d;
`endif
        end
    end

    assign led_r_o       = led_q[0];
    assign led_g_o       = led_q[1];
    assign led_b_o       = led_q[2];
    assign frame_start_o = fs_q;
endmodule
